// File: rtl/systolic_array_param.sv
// systolic_array_param: N x N output-stationary systolic multiplier, C = A x B.
// Signed DW-bit operands; the inner dimension K is given at run time through k_len.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start, k_len      begin a new product (accepted in IDLE/DONE); K sampled with start
//   in_valid/in_ready one beat = A column k (data1) and B row k (data2)
//   data1, data2      lane i at bits DW*i +: DW
//   busy              LOAD or DRAIN
//   done              results valid (level)
//   ovf               sticky accumulator clamp flag (always 0 in the wrap build)
//   rd_row, rd_col    result select; dout = C[rd_row][rd_col] (0 for index >= N)
//
// Build option: define SYSTOLIC_SAT_EN to saturate accumulators and enable ovf;
// otherwise accumulators wrap two's-complement.
module systolic_array_param #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 24,
  parameter int unsigned KW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        data1,
  input  logic [N*DW-1:0]        data2,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  input  logic [$clog2(N)-1:0]   rd_row,
  input  logic [$clog2(N)-1:0]   rd_col,
  output logic [AW-1:0]          dout
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned DCW = $clog2(2 * N);
  localparam logic [DCW-1:0] DrainLast = DCW'(2 * N - 2);
  localparam logic [IW:0]    NLim      = (IW + 1)'(N);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_q;
  logic [DCW-1:0] drain_q;
  logic           start_acc;
  logic           adv;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    adv       = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (k_len == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          adv = 1'b1;
          if (beat_q == k_q - KW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Zero operands flush the last k through the farthest PE (i + j = 2N-2).
        adv = 1'b1;
        if (drain_q == DrainLast) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q == StLoad) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else if (start_acc) begin
      k_q     <= k_len;
      beat_q  <= '0;
      drain_q <= '0;
    end else if (state_q == StLoad && in_valid) begin
      beat_q  <= beat_q + KW'(1);
    end else if (state_q == StDrain) begin
      drain_q <= drain_q + DCW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Input skew: lane i is delayed i advance steps. Zeros are injected in DRAIN.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_inj, b_inj;
    assign a_inj = in_ready ? data1[DW*i +: DW] : '0;
    assign b_inj = in_ready ? data2[DW*i +: DW] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_inj;
      assign b_edge[i] = b_inj;
    end else begin : g_delay
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (start_acc) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (adv) begin
          a_sr[0] <= a_inj;
          b_sr[0] <= b_inj;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid: A moves right, B moves down, each PE keeps its own accumulator.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] a_pipe [N][N-1];  // registered A leaving PE(i,j) to the right
  logic [DW-1:0] b_pipe [N-1][N];  // registered B leaving PE(i,j) downward
  logic [AW-1:0] acc_2d [N][N];

`ifdef SYSTOLIC_SAT_EN
  localparam logic [AW-1:0] AccMax = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] AccMin = {1'b1, {(AW-1){1'b0}}};
  logic [N*N-1:0] clamp_vec;
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DW-1:0]   a_in, b_in;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   prod_ext;
      logic signed [AW-1:0]   acc_q, acc_d;

      if (j == 0) begin : g_ain
        assign a_in = a_edge[i];
      end else begin : g_ain
        assign a_in = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_bin
        assign b_in = b_edge[j];
      end else begin : g_bin
        assign b_in = b_pipe[i-1][j];
      end

      if (j < N - 1) begin : g_aout
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)            a_q <= '0;
          else if (start_acc) a_q <= '0;
          else if (adv)       a_q <= a_in;
        end
        assign a_pipe[i][j] = a_q;
      end
      if (i < N - 1) begin : g_bout
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)            b_q <= '0;
          else if (start_acc) b_q <= '0;
          else if (adv)       b_q <= b_in;
        end
        assign b_pipe[i][j] = b_q;
      end

      assign prod     = a_in * b_in;
      assign prod_ext = AW'(prod);

`ifdef SYSTOLIC_SAT_EN
      logic signed [AW:0] sum;
      logic               clamp;
      assign sum   = (AW + 1)'(acc_q) + (AW + 1)'(prod_ext);
      // One extra bit disagreeing with the sign bit means the AW-bit range was left.
      assign clamp = sum[AW] ^ sum[AW-1];
      assign acc_d = clamp ? (sum[AW] ? AccMin : AccMax) : sum[AW-1:0];
      assign clamp_vec[i*N+j] = clamp;
`else
      assign acc_d = acc_q + prod_ext;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)            acc_q <= '0;
        else if (start_acc) acc_q <= '0;
        else if (adv)       acc_q <= acc_d;
      end
      assign acc_2d[i][j] = acc_q;
    end
  end

`ifdef SYSTOLIC_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ovf_q <= 1'b0;
    else if (start_acc)          ovf_q <= 1'b0;
    else if (adv && |clamp_vec)  ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Readout
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = '0;
    if (({1'b0, rd_row} < NLim) && ({1'b0, rd_col} < NLim)) begin
      dout = acc_2d[rd_row][rd_col];
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// Bench for systolic_array_param. Two instances share all stimulus: a wide
// accumulator (AW=24) and a narrow one (AW=16) that exercises wrap/saturation.
module tb_systolic_array_param;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KW   = 8;
  localparam int MaxK = 8;
`ifdef SYSTOLIC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic [N*DW-1:0] data1 = '0;
  logic [N*DW-1:0] data2 = '0;
  logic [1:0]     rd_row = '0;
  logic [1:0]     rd_col = '0;

  logic        in_ready_w, busy_w, done_w, ovf_w;
  logic [23:0] dout_w;
  logic        in_ready_n, busy_n, done_n, ovf_n;
  logic [15:0] dout_n;

  systolic_array_param #(.N(N), .DW(DW), .AW(24), .KW(KW)) dut_w (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready_w), .data1(data1), .data2(data2), .busy(busy_w), .done(done_w),
    .ovf(ovf_w), .rd_row(rd_row), .rd_col(rd_col), .dout(dout_w)
  );

  systolic_array_param #(.N(N), .DW(DW), .AW(16), .KW(KW)) dut_n (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready_n), .data1(data1), .data2(data2), .busy(busy_n), .done(done_n),
    .ovf(ovf_n), .rd_row(rd_row), .rd_col(rd_col), .dout(dout_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: records accepted beats, computes C by plain matrix product
  // ---------------------------------------------------------------------------
  int     m_st = 0;  // 0 idle, 1 load, 2 drain, 3 done
  int     m_k = 0, m_beats = 0, m_drain = 0;
  int     ma [MaxK][N];
  int     mb [MaxK][N];
  longint cw [N][N];
  longint cn [N][N];
  bit     m_ovf_w = 1'b0, m_ovf_n = 1'b0;

  function automatic longint fit(input longint v, input int w, inout bit o);
    longint hi, lo, m, r;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (Sat) begin
      if (v > hi) begin o = 1'b1; return hi; end
      if (v < lo) begin o = 1'b1; return lo; end
      return v;
    end
    m = longint'(1) << w;
    r = (v - lo) % m;
    if (r < 0) r += m;
    return r + lo;
  endfunction

  function automatic void clear_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cw[i][j] = 0;
        cn[i][j] = 0;
      end
  endfunction

  function automatic void compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < m_k; k++) begin
          cw[i][j] = fit(cw[i][j] + longint'(ma[k][i]) * mb[k][j], 24, m_ovf_w);
          cn[i][j] = fit(cn[i][j] + longint'(ma[k][i]) * mb[k][j], 16, m_ovf_n);
        end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_k = 0; m_beats = 0; m_drain = 0;
      clear_c();
      m_ovf_w = 1'b0; m_ovf_n = 1'b0;
    end else begin
      case (m_st)
        0, 3: if (start) begin
          clear_c();
          m_ovf_w = 1'b0; m_ovf_n = 1'b0;
          if (k_len == 0) m_st = 3;
          else begin m_k = int'(k_len); m_beats = 0; m_st = 1; end
        end
        1: if (in_valid) begin
          for (int i = 0; i < N; i++) begin
            ma[m_beats][i] = int'($signed(data1[DW*i +: DW]));
            mb[m_beats][i] = int'($signed(data2[DW*i +: DW]));
          end
          m_beats++;
          if (m_beats == m_k) begin m_st = 2; m_drain = 0; end
        end
        2: begin
          m_drain++;
          if (m_drain == 2 * N - 1) begin compute_c(); m_st = 3; end
        end
        default: m_st = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_w", done_w, longint'(m_st == 3));
      check("done_n", done_n, longint'(m_st == 3));
      check("busy_w", busy_w, longint'(m_st == 1 || m_st == 2));
      check("busy_n", busy_n, longint'(m_st == 1 || m_st == 2));
      check("in_ready_w", in_ready_w, longint'(m_st == 1));
      check("in_ready_n", in_ready_n, longint'(m_st == 1));
      check("ovf_w", ovf_w, longint'(m_ovf_w));
      check("ovf_n", ovf_n, longint'(m_ovf_n));
      if (m_st == 3) begin
        check("dout_w", $signed(dout_w), cw[rd_row][rd_col]);
        check("dout_n", $signed(dout_n), cn[rd_row][rd_col]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int     ta [MaxK][N];
  int     tb [MaxK][N];
  bit     vpat [16];
  int     vlen = 0;
  int     ign1 = -1, ign2 = -1;
  int     abort_at = -1;
  longint lw [N][N];
  longint ln [N][N];

  // Starts a product and feeds k beats; lat = cycles from the start edge to done.
  task automatic run(input int k, output int lat);
    int b, idx;
    bit v;
    b = 0;
    idx = 0;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done_w && lat < 200 && lat != abort_at) begin
      start = (lat == ign1) || (lat == ign2);
      if (b < k) begin
        v = (idx < vlen) ? vpat[idx] : 1'b1;
        idx++;
        in_valid = v;
        for (int i = 0; i < N; i++) begin
          data1[DW*i +: DW] = DW'(ta[b][i]);
          data2[DW*i +: DW] = DW'(tb[b][i]);
        end
        if (v) b++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (lat >= 200) check("run_timeout", lat, 0);
  endtask

  task automatic sweep(input string name);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        rd_row = 2'(r);
        rd_col = 2'(c);
        #1;
        check({name, "_w"}, $signed(dout_w), lw[r][c]);
        check({name, "_n"}, $signed(dout_n), ln[r][c]);
      end
  endtask

  task automatic fill(input int av, input int bv);
    for (int k = 0; k < MaxK; k++)
      for (int i = 0; i < N; i++) begin
        ta[k][i] = av;
        tb[k][i] = bv;
      end
  endtask

  task automatic fill_lit(input longint vw, input longint vn);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lw[r][c] = vw;
        ln[r][c] = vn;
      end
  endtask

  initial begin
    int lat;

    // Reset state
    #12;
    check("rst_done", done_w, 0);
    check("rst_busy", busy_w, 0);
    check("rst_in_ready", in_ready_n, 0);
    check("rst_ovf", ovf_n, 0);
    check("rst_dout", dout_w, 0);
    rst = 1'b0;

    // 1: identity A, B[k][j] = 4k+j
    for (int k = 0; k < MaxK; k++)
      for (int i = 0; i < N; i++) begin
        ta[k][i] = (i == k) ? 1 : 0;
        tb[k][i] = 4 * k + i;
      end
    vlen = 0;
    run(4, lat);
    check("t1_latency", lat, 11);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lw[r][c] = 4 * r + c;
        ln[r][c] = 4 * r + c;
      end
    sweep("t1_c");
    check("t1_ovf", ovf_n, 0);

    // 6: start pulses during LOAD (lat 1) and DRAIN (lat 6) are ignored
    ign1 = 1;
    ign2 = 6;
    run(4, lat);
    ign1 = -1;
    ign2 = -1;
    check("t6_latency", lat, 11);
    sweep("t6_c");

    // 2: all -128, stalls 1,0,0,1,0,1
    fill(-128, -128);
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
    vlen = 6;
    run(3, lat);
    vlen = 0;
    check("t2_latency", lat, 13);
    fill_lit(49152, Sat ? 32767 : -16384);
    sweep("t2_c");
    check("t2_ovf_n", ovf_n, Sat ? 1 : 0);
    check("t2_ovf_w", ovf_w, 0);

    // 5: all 127, K=3 -> 48387 exceeds the 16-bit range
    fill(127, 127);
    run(3, lat);
    check("t5_latency", lat, 10);
    fill_lit(48387, Sat ? 32767 : -17149);
    sweep("t5_c");
    check("t5_ovf_n", ovf_n, Sat ? 1 : 0);

    // 3: k_len = 0 after a nonzero result
    run(0, lat);
    check("t3_latency", lat, 0);
    check("t3_busy", busy_w, 0);
    check("t3_ovf_n", ovf_n, 0);
    fill_lit(0, 0);
    sweep("t3_c");

    // 4: reset pulsed mid-DRAIN, then a clean K=2 run
    fill(3, -2);
    abort_at = 7;
    run(4, lat);
    abort_at = -1;
    #3;
    rst = 1'b1;
    #1;
    check("t4_done", done_w, 0);
    check("t4_busy", busy_n, 0);
    check("t4_dout_w", dout_w, 0);
    check("t4_dout_n", dout_n, 0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < MaxK; k++)
      for (int i = 0; i < N; i++) begin
        ta[k][i] = k + i + 1;
        tb[k][i] = i - k;
      end
    run(2, lat);
    check("t4_latency", lat, 9);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lw[r][c] = (r + 1) * c + (r + 2) * (c - 1);
        ln[r][c] = lw[r][c];
      end
    sweep("t4_c");

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_fail);
    $fatal(1);
  end

endmodule
